// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction memory req/ack bus between fetch_queue and imem
interface fetch_queue_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch stage with req/ack imem interface and decode FIFO
// Optional static BTFN prediction when FETCH_BTFN_EN is defined.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RESET,
   fetch_queue_if.master   imem,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stallD,
   output logic [31:0]     insD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            validD,
   output logic            predD
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t          state;
   logic            req_q;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] drain_addr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_after;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] next_pc;

   logic [31:0]     ins_mem [DEPTH];
   logic [XLEN-1:0] pc_mem  [DEPTH];

   assign push        = (state == REQ) && imem.imem_ack && !redirect;
   assign pop         = validD && !stallD;
   assign count_after = count + CW'(push) - CW'(pop);
   assign validD      = (count != '0);

   // During DRAIN the bus must keep showing the abandoned address until its ack.
   assign imem.imem_req  = req_q;
   assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;

   assign insD     = validD ? ins_mem[rd_ptr] : NOP;
   assign PCD      = validD ? pc_mem[rd_ptr] : '0;
   assign PCPlus4D = validD ? pc_mem[rd_ptr] + XLEN'(4) : '0;

`ifdef FETCH_BTFN_EN
   logic [20:0]    j_imm;
   logic [12:0]    b_imm;
   logic           pred_in;
   logic [DEPTH-1:0] pred_mem;

   assign j_imm = {imem.imem_rdata[31], imem.imem_rdata[19:12], imem.imem_rdata[20],
                   imem.imem_rdata[30:21], 1'b0};
   assign b_imm = {imem.imem_rdata[31], imem.imem_rdata[7], imem.imem_rdata[30:25],
                   imem.imem_rdata[11:8], 1'b0};

   always_comb begin
      next_pc = pc + XLEN'(4);
      pred_in = 1'b0;
      if (imem.imem_rdata[6:0] == 7'b1101111) begin
         next_pc = pc + {{(XLEN-21){j_imm[20]}}, j_imm};
         pred_in = 1'b1;
      end else if (imem.imem_rdata[6:0] == 7'b1100011 && imem.imem_rdata[31]) begin
         next_pc = pc + {{(XLEN-13){b_imm[12]}}, b_imm};
         pred_in = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) pred_mem[wr_ptr] <= pred_in;
   end

   assign predD = validD & pred_mem[rd_ptr];
`else
   assign next_pc = pc + XLEN'(4);
   assign predD   = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (push) begin
         ins_mem[wr_ptr] <= imem.imem_rdata;
         pc_mem[wr_ptr]  <= pc;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         req_q      <= 1'b0;
         pc         <= RESET_PC;
         drain_addr <= RESET_PC;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         // A redirect flushes the queue regardless of any same-cycle push or pop.
         if (redirect) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            count <= count_after;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end

         case (state)
            IDLE: begin
               if (redirect) begin
                  pc <= redirect_pc;
               end else if (count < CW'(DEPTH)) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
            end
            REQ: begin
               if (imem.imem_ack) begin
                  if (redirect) begin
                     pc    <= redirect_pc;
                     state <= IDLE;
                     req_q <= 1'b0;
                  end else begin
                     pc <= next_pc;
                     if (count_after >= CW'(DEPTH)) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                     end
                  end
               end else if (redirect) begin
                  drain_addr <= pc;
                  pc         <= redirect_pc;
                  state      <= DRAIN;
               end
            end
            DRAIN: begin
               if (redirect) pc <= redirect_pc;
               if (imem.imem_ack) begin
                  state <= IDLE;
                  req_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue (directed scenarios + random vs queue model)
module tb_fetch_queue;
   logic        CLK = 1'b0;
   logic        RESET;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stallD;
   logic [31:0] insD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        validD;
   logic        predD;
   int          total = 0;
   int          bad = 0;

   fetch_queue_if #(.XLEN(32)) bus ();

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .CLK(CLK), .RESET(RESET), .imem(bus), .redirect(redirect), .redirect_pc(redirect_pc),
      .stallD(stallD), .insD(insD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD), .predD(predD)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {logic [31:0] ins; logic [31:0] pc;} ent_t;

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset;
      RESET = 1'b1; redirect = 1'b0; redirect_pc = '0; stallD = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0;
      tick; tick;
      RESET = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h want=0", bus.imem_req); end
      total++; if (validD !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", validD); end
      total++; if (insD !== 32'h13) begin bad++; $display("FAIL reset_ins got=%h want=00000013", insD); end
      total++; if ({PCD, PCPlus4D} !== 64'h0) begin bad++; $display("FAIL reset_pcd got=%h/%h want=0/0", PCD, PCPlus4D); end
      total++; if (predD !== 1'b0) begin bad++; $display("FAIL reset_pred got=%0h want=0", predD); end
      total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.imem_addr); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd;
      do_reset;
      tick;
      total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL b2b_req got=%0h want=1", bus.imem_req); end
      for (int k = 0; k < 4; k++) begin
         total++; if (bus.imem_addr !== 32'(4*k)) begin bad++; $display("FAIL b2b_addr%0d got=%h want=%h", k, bus.imem_addr, 4*k); end
         rd = 32'h00100093 + 32'(k) * 32'h00100080;
         bus.imem_ack = 1'b1; bus.imem_rdata = rd;
         tick;
         total++;
         if ({validD, PCD, PCPlus4D, insD} !== {1'b1, 32'(4*k), 32'(4*k+4), rd}) begin
            bad++; $display("FAIL b2b_head%0d got=%0h/%h/%h/%h want=1/%h/%h/%h", k, validD, PCD, PCPlus4D, insD, 4*k, 4*k+4, rd);
         end
      end
      bus.imem_ack = 1'b0;
   endtask

   task automatic test_stall;
      int pushes = 0;
      do_reset;
      stallD = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00000013;
      for (int c = 0; c < 10; c++) begin
         if (bus.imem_req === 1'b1) pushes++;
         tick;
      end
      bus.imem_ack = 1'b0;
      total++; if (pushes !== 4) begin bad++; $display("FAIL stall_pushes got=%0d want=4", pushes); end
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%0h want=0", bus.imem_req); end
      total++; if ({validD, PCD} !== {1'b1, 32'h0}) begin bad++; $display("FAIL stall_head got=%0h/%h want=1/0", validD, PCD); end
      stallD = 1'b0;
      tick;
      total++; if ({bus.imem_req, PCD} !== {1'b0, 32'h4}) begin bad++; $display("FAIL stall_pop1 got=%0h/%h want=0/4", bus.imem_req, PCD); end
      tick;
      total++; if ({bus.imem_req, bus.imem_addr, PCD} !== {1'b1, 32'h10, 32'h8}) begin
         bad++; $display("FAIL stall_restart got=%0h/%h/%h want=1/10/8", bus.imem_req, bus.imem_addr, PCD);
      end
   endtask

   task automatic test_drain;
      do_reset;
      stallD = 1'b1;
      tick;
      bus.imem_ack = 1'b1; tick; tick;
      bus.imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
      tick;
      redirect = 1'b0;
      total++; if ({bus.imem_req, bus.imem_addr, validD} !== {1'b1, 32'h8, 1'b0}) begin
         bad++; $display("FAIL drain_enter got=%0h/%h/%0h want=1/8/0", bus.imem_req, bus.imem_addr, validD);
      end
      for (int c = 0; c < 2; c++) begin
         tick;
         total++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) begin
            bad++; $display("FAIL drain_hold%0d got=%0h/%h want=1/8", c, bus.imem_req, bus.imem_addr);
         end
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
      tick;
      bus.imem_ack = 1'b0;
      total++; if ({bus.imem_req, validD} !== 2'b00) begin bad++; $display("FAIL drain_ack got=%0h/%0h want=0/0", bus.imem_req, validD); end
      tick;
      total++; if ({bus.imem_req, bus.imem_addr, validD} !== {1'b1, 32'h40, 1'b0}) begin
         bad++; $display("FAIL drain_restart got=%0h/%h/%0h want=1/40/0", bus.imem_req, bus.imem_addr, validD);
      end
      stallD = 1'b0;
   endtask

   task automatic test_redirect_ack;
      do_reset;
      stallD = 1'b1;
      tick;
      bus.imem_ack = 1'b1; tick; tick;
      stallD = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
      tick;
      bus.imem_ack = 1'b0; redirect = 1'b0;
      total++; if ({validD, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b0, 32'h80}) begin
         bad++; $display("FAIL redir_ack got=%0h/%0h/%h want=0/0/80", validD, bus.imem_req, bus.imem_addr);
      end
      tick;
      total++; if ({validD, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h80}) begin
         bad++; $display("FAIL redir_restart got=%0h/%0h/%h want=0/1/80", validD, bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      tick;
      RESET = 1'b1;
      tick;
      RESET = 1'b0;
      total++; if ({bus.imem_req, validD, bus.imem_addr} !== {1'b0, 1'b0, 32'h0}) begin
         bad++; $display("FAIL rstmid got=%0h/%0h/%h want=0/0/0", bus.imem_req, validD, bus.imem_addr);
      end
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h12345013;
      tick;
      bus.imem_ack = 1'b0;
      total++; if ({validD, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
         bad++; $display("FAIL rstmid_stray got=%0h/%0h/%h want=0/1/0", validD, bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_wrap;
      do_reset;
      redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
      tick;
      redirect = 1'b0;
      total++; if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'hFFFFFFFC}) begin
         bad++; $display("FAIL wrap_idle got=%0h/%h want=0/fffffffc", bus.imem_req, bus.imem_addr);
      end
      tick;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00000013;
      tick;
      bus.imem_ack = 1'b0;
      total++; if ({PCD, PCPlus4D, bus.imem_addr} !== {32'hFFFFFFFC, 32'h0, 32'h0}) begin
         bad++; $display("FAIL wrap_pc got=%h/%h/%h want=fffffffc/0/0", PCD, PCPlus4D, bus.imem_addr);
      end
   endtask

   task automatic test_btfn;
      logic        exp_pred;
      logic [31:0] exp_addr;
`ifdef FETCH_BTFN_EN
      exp_pred = 1'b1; exp_addr = 32'h1C;
`else
      exp_pred = 1'b0; exp_addr = 32'h24;
`endif
      do_reset;
      redirect = 1'b1; redirect_pc = 32'h20;
      tick;
      redirect = 1'b0;
      tick;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFE000EE3;
      tick;
      bus.imem_ack = 1'b0;
      total++; if ({PCD, predD, bus.imem_addr} !== {32'h20, exp_pred, exp_addr}) begin
         bad++; $display("FAIL btfn got=%h/%0h/%h want=20/%0h/%h", PCD, predD, bus.imem_addr, exp_pred, exp_addr);
      end
   endtask

   task automatic test_random;
      ent_t        q[$];
      bit          busy = 0;
      bit          want = 0;
      logic [31:0] mpc = 0;
      logic [31:0] maddr = 0;
      logic [31:0] r;
      logic [31:0] t;
      logic [97:0] exp_head;
      int          n;
      bit          pop;
      bit          push;
      do_reset;
      for (int c = 0; c < 400; c++) begin
         total++; if (bus.imem_req !== busy) begin bad++; $display("FAIL rnd_req c=%0d got=%0h want=%0h", c, bus.imem_req, busy); end
         if (busy) begin
            total++; if (bus.imem_addr !== maddr) begin bad++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, bus.imem_addr, maddr); end
         end
         exp_head = (q.size() != 0) ? {1'b1, q[0].ins, q[0].pc, q[0].pc + 32'd4, 1'b0}
                                    : {1'b0, 32'h13, 32'h0, 32'h0, 1'b0};
         total++;
         if ({validD, insD, PCD, PCPlus4D, predD} !== exp_head) begin
            bad++; $display("FAIL rnd_head c=%0d got=%h want=%h", c, {validD, insD, PCD, PCPlus4D, predD}, exp_head);
         end
         r = $urandom; t = $urandom;
         bus.imem_ack   = busy && (r[1:0] != 2'b00);
         bus.imem_rdata = {t[31:7], 7'b0010011};
         stallD         = (r[3:2] == 2'b00);
         redirect       = (r[8:4] == 5'd0);
         redirect_pc    = {22'h0, r[17:10], 2'b00};
         n    = q.size();
         pop  = (n > 0) && !stallD;
         push = busy && want && bus.imem_ack && !redirect;
         if (redirect) begin
            q.delete();
            mpc = redirect_pc;
         end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
               q.push_back({bus.imem_rdata, mpc});
               mpc = mpc + 32'd4;
            end
         end
         if (!busy) begin
            if (!redirect && n < 4) begin busy = 1; want = 1; maddr = mpc; end
         end else if (bus.imem_ack) begin
            if (push && q.size() < 4) begin want = 1; maddr = mpc; end
            else busy = 0;
         end else if (redirect) begin
            want = 0;
         end
         tick;
      end
      bus.imem_ack = 1'b0; redirect = 1'b0; stallD = 1'b0;
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_stall;
      test_drain;
      test_redirect_ack;
      test_reset_mid;
      test_wrap;
      test_btfn;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch stage. Replaces the PC register, PC+4 adder, PC-select mux and IF/ID register with a single block.
- Talks to instruction memory over a req/ack handshake, so memory may have variable latency.
- Buffers fetched instructions in a DEPTH-entry FIFO that feeds decode.
- Accepts EX-stage redirects and decode stalls. Sits between the instruction memory and the decoder.

Parameters:
XLEN, 32, PC and address width.
DEPTH, 4, number of FIFO entries (power of 2, ≥2).
RESET_PC, 0, fetch address after reset.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RESET  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request; registered; high in REQ and DRAIN.
imem_addr  out  XLEN  fetch address; stable while imem_req=1 and imem_ack=0.
imem_ack  in  1  memory response valid this cycle; imem_rdata is sampled with it.
imem_rdata  in  32  fetched instruction.
redirect  in  1  PCSrcE from EX; flush and restart fetch.
redirect_pc  in  XLEN  PCTargetE.
stallD  in  1  decode cannot accept; hold the head entry.
insD  out  32  head instruction; 32'h00000013 (NOP) when validD=0.
PCD  out  XLEN  head PC; 0 when validD=0.
PCPlus4D  out  XLEN  head PC+4; 0 when validD=0.
validD  out  1  FIFO not empty.
predD  out  1  head entry was predicted taken (see Optional Feature).

Behaviour:
- Reset values: state=IDLE, fetch pc=RESET_PC, count=0, FIFO pointers=0, imem_req=0, validD=0, insD=NOP, PCD=0, PCPlus4D=0, predD=0.
- States: IDLE (no request), REQ (request outstanding, data wanted), DRAIN (request outstanding, data to be discarded).
- At most one request is outstanding. imem_addr = fetch pc register.
- IDLE -> REQ when count<DEPTH and redirect=0. IDLE + redirect: pc<=redirect_pc and stay IDLE for that cycle.
- REQ, imem_ack=1, redirect=0:
  - Push {imem_rdata, pc, pc+4, pred} into the FIFO; pc<=next_pc.
  - Next state REQ if count_after < DEPTH, else IDLE.
  - With ack held high every cycle, throughput is 1 instruction/cycle.
- REQ, imem_ack=0, redirect=1: go to DRAIN; pc<=redirect_pc. Keep req high and imem_addr at the old address until ack.
- REQ, imem_ack=1, redirect=1: drop the data; pc<=redirect_pc; next state IDLE.
- DRAIN, imem_ack=1: drop the data; next state IDLE. A redirect in DRAIN only updates pc; the latest redirect wins.
- Pop when validD=1 and stallD=0. The next head appears on the following cycle.
- Latency: ack at edge N -> validD=1 after edge N (empty FIFO). The entry is visible to decode in the cycle after ack.
- redirect=1 clears the FIFO at the edge (count<=0, pointers reset), overriding any same-cycle pop or push. validD=0 the next cycle.
- Simultaneous push and pop: count unchanged.
- Overflow is impossible: a request is only issued when count<DEPTH, and pops only reduce count.
- A pop on an empty FIFO is ignored.
- count width: clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- All pc arithmetic is modulo 2^XLEN, so 0xFFFFFFFC+4 = 0.
- RESET mid-transaction: the request is abandoned (imem_req=0 next cycle). Instruction memory must ignore an ack for an abandoned request; the block ignores any ack while in IDLE.

Optional Feature:
- Macro FETCH_BTFN_EN.
- Defined: static backward-taken/forward-not-taken prediction at push.
  - opcode 1101111 (JAL): next_pc = pc + J-imm; pred=1.
  - opcode 1100011 (branch) with imm[12]=1 (backward): next_pc = pc + B-imm; pred=1.
  - Otherwise: next_pc = pc+4; pred=0.
  - EX must redirect to PCPlus4 when a predicted branch is not taken.
- Undefined: next_pc = pc+4 always; predD tied to 0; no decode logic is synthesised.

Test Plan:
- Reset then ack every cycle with rdata = 0x00100093, 0x00200113, ... -> imem_addr sequence 0, 4, 8, C; validD first high after the first ack; PCD 0, 4, 8 on successive cycles with stallD=0.
- stallD=1 held, ack every cycle, DEPTH=4 -> exactly 4 pushes, then imem_req=0 with count=4. Release stallD -> pops resume and fetch restarts at 0x10.
- Request at 0x8 outstanding, redirect=1 with redirect_pc=0x40, ack 3 cycles later -> DRAIN: imem_addr stays 0x8, data discarded, next request at 0x40, FIFO empty, validD=0.
- redirect in the same cycle as ack and pop with FIFO count=2 -> FIFO cleared, no push, next imem_addr=redirect_pc.
- RESET asserted during REQ -> imem_req=0, validD=0, pc=RESET_PC next cycle; a later stray ack causes no push.
- With FETCH_BTFN_EN: at pc=0x20, rdata=0xFE000EE3 (beq, imm=-4) -> predD=1 on that entry and next imem_addr=0x1C. Without the macro -> next imem_addr=0x24, predD=0.
